// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the CPU/cache/RAM codebase slice.
//   ramstate_t  : RAM controller status (FREE, BUSY, ACCESS, ERROR)
//   word_t      : 32-bit machine word
//   arb_state_t : memory_arbiter FSM states (IDLE, GRANT)
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req   in  N   request vector
//   ptr   in  IW  index to start searching from (cyclic)
//   found out 1   at least one request is set
//   idx   out IW  first set request at or after ptr
module rr_picker #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic [IW-1:0] cand;
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter between the dcache/icache pairs of
// CPUS cores and a single-ported RAM. Requester 2c is dcache c, 2c+1 is
// icache c. Grant is registered; RAM strobes/address follow the granted
// requester's live inputs while in GRANT.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   dREN/dWEN/daddr/dstore  per-core data request, address, write data
//   dwait/dload             per-core data wait (1 = not done) and read data
//   iREN/iaddr              per-core instruction request and address
//   iwait/iload             per-core instruction wait and read data
//   ramREN/ramWEN/ramaddr/ramstore  RAM request side
//   ramload/ramstate        RAM read data and status
//
// Build option: define ARB_BURST_EN to let one requester keep the grant for
// up to MAX_BURST consecutive words without an IDLE bubble.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS      = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [CPUS-1:0]    dREN,
   input  logic [CPUS-1:0]    dWEN,
   input  logic [CPUS*AW-1:0] daddr,
   input  logic [CPUS*DW-1:0] dstore,
   output logic [CPUS-1:0]    dwait,
   output logic [CPUS*DW-1:0] dload,
   input  logic [CPUS-1:0]    iREN,
   input  logic [CPUS*AW-1:0] iaddr,
   output logic [CPUS-1:0]    iwait,
   output logic [CPUS*DW-1:0] iload,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [AW-1:0]      ramaddr,
   output logic [DW-1:0]      ramstore,
   input  logic [DW-1:0]      ramload,
   input  logic [1:0]         ramstate
);

   localparam int N  = 2 * CPUS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

`ifdef ARB_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   arb_state_t    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant_id;
   logic [BW-1:0] burst_cnt;

   logic [N-1:0]  req;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] next_ptr;
   logic          gnt_active;
   logic          done;
   logic          hold;

   for (genvar g = 0; g < CPUS; g++) begin : g_req
      assign req[2*g]   = dREN[g] | dWEN[g];
      assign req[2*g+1] = iREN[g];
   end

   rr_picker #(.N(N)) u_picker (
      .req   (req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Read data is broadcast; each consumer qualifies it with its own wait.
   assign dload = {CPUS{ramload}};
   assign iload = {CPUS{ramload}};

   assign next_ptr = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      dwait      = '1;
      iwait      = '1;
      gnt_active = req[grant_id];
      done       = 1'b0;
      if (state == GRANT) begin
         done = gnt_active && (ramstate_t'(ramstate) == ACCESS);
         for (int unsigned c = 0; c < CPUS; c++) begin
            if (grant_id == IW'(2 * c)) begin
               ramaddr  = daddr[c*AW +: AW];
               ramstore = dstore[c*DW +: DW];
               // a write takes precedence over a simultaneous read
               ramWEN   = dWEN[c];
               ramREN   = dREN[c] & ~dWEN[c];
               dwait[c] = ~done;
            end else if (grant_id == IW'(2 * c + 1)) begin
               ramaddr  = iaddr[c*AW +: AW];
               ramREN   = iREN[c];
               iwait[c] = ~done;
            end
         end
      end
      hold = BURST_EN && done && (burst_cnt < BW'(MAX_BURST - 1));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (hold) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else if (done || !gnt_active) begin
                  // completion or abandoned request: rotate past this requester
                  rr_ptr    <= next_ptr;
                  burst_cnt <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

   localparam int CPUS      = 2;
   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int MAX_BURST = 4;
   localparam int N         = 2 * CPUS;

`ifdef ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

   logic               CLK = 1'b0;
   logic               RST;
   logic [CPUS-1:0]    dREN, dWEN, iREN;
   logic [CPUS*AW-1:0] daddr, iaddr;
   logic [CPUS*DW-1:0] dstore, dload, iload;
   logic [CPUS-1:0]    dwait, iwait;
   logic               ramREN, ramWEN;
   logic [AW-1:0]      ramaddr;
   logic [DW-1:0]      ramstore, ramload;
   logic [1:0]         ramstate;

   memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .CLK(CLK), .RST(RST),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the RAM (-1 = nobody), where the next search
   // starts, and how many words the owner has completed in this grant.
   int owner = -1, ptr = 0, words = 0;
   int n_owner, n_ptr, n_words;
   logic          e_ren, e_wen;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_store;
   logic [CPUS-1:0] e_dw, e_iw;

   int cyc = 0;
   int obs_r[$];
   int obs_c[$];

   // cache-like requester drivers
   int          pend[N];
   bit          wr[N];
   bit          both[N];
   logic [31:0] raddr[N];
   logic [31:0] rdat[N];

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, a, e);
      end
   endtask

   function automatic bit active(int r);
      if (r % 2 == 0) return dREN[r/2] | dWEN[r/2];
      return iREN[r/2];
   endfunction

   task automatic model_eval();
      int c;
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_dw = '1; e_iw = '1;
      n_owner = owner; n_ptr = ptr; n_words = words;
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (n_owner < 0 && active((ptr + k) % N)) n_owner = (ptr + k) % N;
         end
      end else begin
         c = owner / 2;
         if (owner % 2 == 1) begin
            e_addr = iaddr[c*AW +: AW];
            e_ren  = iREN[c];
         end else begin
            e_addr  = daddr[c*AW +: AW];
            e_store = dstore[c*DW +: DW];
            e_wen   = dWEN[c];
            e_ren   = dREN[c] && !dWEN[c];
         end
         if (!active(owner)) begin
            n_owner = -1; n_ptr = (owner + 1) % N; n_words = 0;
         end else if (ramstate == S_ACC) begin
            if (owner % 2 == 1) e_iw[c] = 1'b0; else e_dw[c] = 1'b0;
            n_words = words + 1;
            if (!(BURST && n_words < MAX_BURST)) begin
               n_owner = -1; n_ptr = (owner + 1) % N; n_words = 0;
            end
         end
      end
      if (RST) begin
         n_owner = -1; n_ptr = 0; n_words = 0;
      end
   endtask

   task automatic tick();
      #2;
      model_eval();
      chk("ramREN", 64'(ramREN), 64'(e_ren));
      chk("ramWEN", 64'(ramWEN), 64'(e_wen));
      chk("dwait", 64'(dwait), 64'(e_dw));
      chk("iwait", 64'(iwait), 64'(e_iw));
      if (owner < 0 || e_ren || e_wen) chk("ramaddr", 64'(ramaddr), 64'(e_addr));
      if (owner < 0 || e_wen) chk("ramstore", 64'(ramstore), 64'(e_store));
      for (int c = 0; c < CPUS; c++) begin
         if (!e_dw[c]) chk("dload", 64'(dload[c*DW +: DW]), 64'(ramload));
         if (!e_iw[c]) chk("iload", 64'(iload[c*DW +: DW]), 64'(ramload));
         if (dwait[c] === 1'b0) begin obs_r.push_back(2*c);   obs_c.push_back(cyc); end
         if (iwait[c] === 1'b0) begin obs_r.push_back(2*c+1); obs_c.push_back(cyc); end
      end
      @(posedge CLK);
      owner = n_owner; ptr = n_ptr; words = n_words;
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      dREN = '0; dWEN = '0; iREN = '0;
      daddr = '0; iaddr = '0; dstore = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      for (int r = 0; r < N; r++) pend[r] = 0;
      tick();
      RST = 1'b0;
      cyc = 0;
      obs_r.delete();
      obs_c.delete();
   endtask

   task automatic apply_caches();
      for (int c = 0; c < CPUS; c++) begin
         dWEN[c] = (pend[2*c] > 0) && wr[2*c];
         dREN[c] = (pend[2*c] > 0) && (!wr[2*c] || both[2*c]);
         daddr[c*AW +: AW]  = raddr[2*c];
         dstore[c*DW +: DW] = rdat[2*c];
         iREN[c] = pend[2*c+1] > 0;
         iaddr[c*AW +: AW] = raddr[2*c+1];
      end
   endtask

   // one cycle of cache traffic; completions advance to the next word
   task automatic cache_cycle();
      apply_caches();
      tick();
      for (int c = 0; c < CPUS; c++) begin
         if (!e_dw[c] && pend[2*c] > 0) begin
            pend[2*c]--; raddr[2*c] += 4; rdat[2*c] = $urandom;
         end
         if (!e_iw[c] && pend[2*c+1] > 0) begin
            pend[2*c+1]--; raddr[2*c+1] += 4;
         end
      end
   endtask

   task automatic check_order(input string nm, input int er[], input int ec[]);
      chk({nm, "_count"}, 64'(obs_r.size() >= er.size()), 64'(1));
      for (int i = 0; i < er.size() && i < obs_r.size(); i++) begin
         chk({nm, "_req"}, 64'(obs_r[i]), 64'(er[i]));
         chk({nm, "_cyc"}, 64'(obs_c[i]), 64'(ec[i]));
      end
   endtask

   typedef struct {
      bit          rst;
      bit [1:0]    dren, dwen, iren;
      logic [1:0]  rs;
      bit          ren, wen;
      bit [1:0]    dw, iw;
      bit          ca;
      logic [31:0] addr;
      logic [31:0] store;
   } vec_t;

   function automatic vec_t mk(bit rst, bit [1:0] dren, bit [1:0] dwen, bit [1:0] iren,
                               logic [1:0] rs, bit ren, bit wen, bit [1:0] dw, bit [1:0] iw,
                               bit ca, logic [31:0] addr, logic [31:0] store);
      vec_t v;
      v.rst = rst; v.dren = dren; v.dwen = dwen; v.iren = iren; v.rs = rs;
      v.ren = ren; v.wen = wen; v.dw = dw; v.iw = iw; v.ca = ca; v.addr = addr; v.store = store;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[17];
      int   rs_pick;

      for (int r = 0; r < N; r++) begin
         pend[r] = 0; wr[r] = 0; both[r] = 0; raddr[r] = 32'h1000 * (r + 1); rdat[r] = 32'hA000 + r;
      end
      RST = 1'b1;
      clear_inputs();
      ramload = 32'h12345678;
      ramstate = S_FREE;
      @(posedge CLK);
      #1;

      // directed vectors: reset, BUSY stretch, write-wins, mid-grant drop
      tbl[0]  = mk(1, 2'b11, 2'b11, 2'b11, S_ACC,  0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[1]  = mk(1, 2'b11, 2'b11, 2'b11, S_ACC,  0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[2]  = mk(0, 2'b00, 2'b00, 2'b01, S_BUSY, 0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[3]  = mk(0, 2'b00, 2'b00, 2'b01, S_BUSY, 1, 0, 2'b11, 2'b11, 1, 32'h100, 32'h0);
      tbl[4]  = mk(0, 2'b00, 2'b00, 2'b01, S_BUSY, 1, 0, 2'b11, 2'b11, 1, 32'h100, 32'h0);
      tbl[5]  = mk(0, 2'b00, 2'b00, 2'b01, S_BUSY, 1, 0, 2'b11, 2'b11, 1, 32'h100, 32'h0);
      tbl[6]  = mk(0, 2'b00, 2'b00, 2'b01, S_ACC,  1, 0, 2'b11, 2'b10, 1, 32'h100, 32'h0);
      tbl[7]  = mk(0, 2'b10, 2'b10, 2'b00, S_ACC,  0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[8]  = mk(0, 2'b10, 2'b10, 2'b00, S_ACC,  0, 1, 2'b01, 2'b11, 1, 32'h40,  32'hDEADBEEF);
      tbl[9]  = mk(0, 2'b00, 2'b00, 2'b00, S_FREE, 0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[10] = mk(0, 2'b00, 2'b00, 2'b10, S_FREE, 0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[11] = mk(0, 2'b00, 2'b00, 2'b10, S_BUSY, 1, 0, 2'b11, 2'b11, 1, 32'h200, 32'h0);
      tbl[12] = mk(0, 2'b11, 2'b00, 2'b00, S_BUSY, 0, 0, 2'b11, 2'b11, 0, 32'h0,   32'h0);
      tbl[13] = mk(0, 2'b11, 2'b00, 2'b00, S_ACC,  0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);
      tbl[14] = mk(0, 2'b11, 2'b00, 2'b00, S_ACC,  1, 0, 2'b10, 2'b11, 1, 32'h10,  32'h0);
      tbl[15] = mk(0, 2'b00, 2'b00, 2'b00, S_ACC,  0, 0, 2'b11, 2'b11, 0, 32'h0,   32'h0);
      tbl[16] = mk(0, 2'b00, 2'b00, 2'b00, S_FREE, 0, 0, 2'b11, 2'b11, 1, 32'h0,   32'h0);

      daddr  = {32'h40, 32'h10};
      iaddr  = {32'h200, 32'h100};
      dstore = {32'hDEADBEEF, 32'h11111111};
      for (int i = 0; i < 17; i++) begin
         RST = tbl[i].rst;
         dREN = tbl[i].dren; dWEN = tbl[i].dwen; iREN = tbl[i].iren;
         ramstate = tbl[i].rs;
         #1;
         chk("vec_ramREN", 64'(ramREN), 64'(tbl[i].ren));
         chk("vec_ramWEN", 64'(ramWEN), 64'(tbl[i].wen));
         chk("vec_dwait", 64'(dwait), 64'(tbl[i].dw));
         chk("vec_iwait", 64'(iwait), 64'(tbl[i].iw));
         if (tbl[i].ca) chk("vec_ramaddr", 64'(ramaddr), 64'(tbl[i].addr));
         if (tbl[i].wen) chk("vec_ramstore", 64'(ramstore), 64'(tbl[i].store));
         if (!tbl[i].iw[0]) chk("vec_iload0", 64'(iload[DW-1:0]), 64'(32'h12345678));
         tick();
      end

      ramstate = S_ACC;
`ifdef ARB_BURST_EN
      // dcache 0 wants 6 words, icache 1 wants 1 word
      do_reset();
      pend[0] = 6; wr[0] = 0; pend[3] = 1;
      for (int i = 0; i < 14; i++) cache_cycle();
      check_order("burst", '{0, 0, 0, 0, 3, 0, 0}, '{1, 2, 3, 4, 6, 8, 9});
`else
      // all four requesters busy, zero-wait RAM
      do_reset();
      for (int r = 0; r < N; r++) pend[r] = 100;
      for (int i = 0; i < 10; i++) cache_cycle();
      check_order("rotation", '{0, 1, 2, 3, 0}, '{1, 3, 5, 7, 9});
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int r = 0; r < N; r++) begin
            if (pend[r] == 0 && $urandom_range(0, 3) == 0) begin
               pend[r]  = $urandom_range(1, 6);
               wr[r]    = (r % 2 == 0) && $urandom_range(0, 1) == 1;
               both[r]  = $urandom_range(0, 3) == 0;
               raddr[r] = $urandom & 32'h0000FFFC;
               rdat[r]  = $urandom;
            end else if (pend[r] > 0 && $urandom_range(0, 39) == 0) begin
               pend[r] = 0;
            end
         end
         rs_pick  = $urandom_range(0, 9);
         ramstate = (rs_pick < 5) ? S_ACC : 2'($urandom_range(0, 3));
         ramload  = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            RST = 1'b1;
            cache_cycle();
            RST = 1'b0;
            for (int r = 0; r < N; r++) pend[r] = 0;
         end else begin
            cache_cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised round-robin arbiter between the instruction and data caches of CPUS cores and the single-ported RAM. Replaces the fixed-priority, purely combinational data-over-instruction mux with a registered grant, fair rotation across all 2*CPUS requesters, and optional grant hold for multi-word block transfers. Sits between the per-core cache pair and the RAM model/controller.

## Interface
- CPUS, 2: number of cores; requester count N = 2*CPUS.
- AW, 32: address width.
- DW, 32: data word width.
- MAX_BURST, 4: maximum consecutive words per grant; used only with ARB_BURST_EN; must be ≥ 1.

- CLK  in  1  clock; one clock; all state on rising edge.
- RST  in  1  reset; synchronous, active-high.
- dREN, dWEN  in  CPUS  per-core data read/write request.
- daddr  in  CPUS x AW  data address.
- dstore  in  CPUS x DW  write data.
- dwait  out  CPUS  1 = data access not complete.
- dload  out  CPUS x DW  read data.
- iREN  in  CPUS  per-core instruction read request.
- iaddr  in  CPUS x AW  instruction address.
- iwait  out  CPUS  1 = instruction access not complete.
- iload  out  CPUS x DW  read data.
- ramREN, ramWEN  out  1  RAM read/write strobe.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.

## Operation
- Requester index r: 2c = dcache of core c, 2c+1 = icache of core c. Requester active if dREN|dWEN (even) or iREN (odd).
- FSM states IDLE, GRANT.
- IDLE: ram strobes 0. If any requester active, select first active at or after rr_ptr (cyclic); register grant_id, go GRANT. No active requester: stay.
- GRANT: ramaddr/ramstore/strobes driven from grant_id's current inputs. Data requester: dWEN set → ramWEN=1, ramREN=0 (write wins over simultaneous dREN). Icache: ramREN only.
- Access completes on a GRANT cycle with ramstate==ACCESS: granted wait = 0 that cycle only. BUSY, FREE, ERROR: wait stays 1, hold.
- On completion (no burst): rr_ptr <= grant_id+1 mod N, go IDLE.
- Granted requester drops its request while in GRANT: strobes drop same cycle, no completion, rr_ptr <= grant_id+1, go IDLE.
- dload/iload: all = ramload (broadcast); valid only when corresponding wait = 0.
- Non-granted waits: always 1.

## Timing
- Reset: state IDLE, rr_ptr 0, grant_id 0, burst count 0; ramREN=ramWEN=0, all dwait/iwait=1, ramaddr/ramstore=0 while IDLE.
- Request at cycle t in IDLE → strobes in t+1 → earliest wait=0 at t+1 if RAM returns ACCESS.
- Minimum one IDLE cycle between grants without burst: zero-wait RAM sustains one word per 2 cycles.
- Reset during GRANT: strobes and grant cleared next edge; outstanding access abandoned.
- Fairness: a continuously active requester is granted within N grants.

## Configuration
- ARB_BURST_EN defined: on completion, if the same requester is still active and burst count < MAX_BURST-1, stay in GRANT, count+1, no IDLE bubble (next word issued the following cycle with new address); else release as above and clear count. Count cleared on every release.
- Undefined: release after every word; MAX_BURST ignored.

## Structure
- cpu_types_pkg: ramstate_t (FREE, BUSY, ACCESS, ERROR), word_t; add arb_state_t (IDLE, GRANT).
- Sub-module rr_picker (parameter N): combinational request vector + rr_ptr → found, index. Everything else in memory_arbiter.

## Test plan
- Reset: RST high 2 cycles with all requests high → all waits 1, ramREN=ramWEN=0, state IDLE.
- CPUS=2, all four requesters active continuously, zero-wait RAM → grant order 0,1,2,3,0; each access completes 2 cycles apart.
- dREN and dWEN both on core 1, daddr=0x40, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramaddr=0x40, ramstore=0xDEADBEEF, dwait[1]=0 on ACCESS.
- RAM holds BUSY 3 cycles then ACCESS for iREN[0] addr 0x100, ramload=0x12345678 → iwait[0]=1 for 4 cycles, 0 for 1 cycle with iload[0]=0x12345678.
- Icache 1 drops iREN mid-GRANT → strobes 0 same cycle, next grant goes to requester 0 (rr_ptr wrapped).
- ARB_BURST_EN, MAX_BURST=4, dcache 0 requests 6 words back-to-back → 4 consecutive completions, one IDLE cycle, re-arbitration, remaining 2 words after other active requesters served.
